if_id_fetch_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the ID/EX register.

---
 rtl/if_id_fetch_stage.sv | 182 ++++++++++++++++++
 tb/tb_if_id_fetch_stage.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_fetch_stage.sv
// rtl/if_id_fetch_stage.sv - instruction fetch stage with IF/ID register, hold buffer and redirect squash
module if_id_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic [4:0]  rs1_out,
  output logic [4:0]  rs2_out,
  output logic [4:0]  rd_out,
  output logic [2:0]  funct3_out,
  output logic [6:0]  funct7_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_redir_pc;
  logic        r_hold_valid;
  logic [31:0] r_hold_pc;
  logic [31:0] r_hold_instr;
  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_instr;

  state_t      w_state_nxt;
  logic [31:0] w_fetch_pc_nxt;
  logic [31:0] w_redir_pc_nxt;
  logic        w_hold_valid_nxt;
  logic [31:0] w_hold_pc_nxt;
  logic [31:0] w_hold_instr_nxt;
  logic        w_valid_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_instr_nxt;

  logic        w_req;
  logic        w_complete;
  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;

  // Word alignment is enforced by masking, so a misaligned target never reaches the bus.
  assign w_target   = redirect_pc & 32'hFFFF_FFFC;
  assign w_pc_plus4 = r_fetch_pc + 32'd4;
  assign w_complete = w_req & imem_ready;

  // Request is a function of registered state only; the address is simply the fetch PC,
  // which in DROP still holds the squashed request's address until it completes.
  always_comb begin
    w_req = 1'b0;
    case (r_state)
      S_IDLE:  w_req = 1'b0;
      S_FETCH: w_req = !r_hold_valid;
      S_DROP:  w_req = 1'b1;
      default: w_req = 1'b0;
    endcase
  end

  assign imem_req  = w_req;
  assign imem_addr = r_fetch_pc;

  // Next-state and next-register values for the fetch FSM and IF/ID register.
  always_comb begin
    w_state_nxt      = r_state;
    w_fetch_pc_nxt   = r_fetch_pc;
    w_redir_pc_nxt   = r_redir_pc;
    w_hold_valid_nxt = r_hold_valid;
    w_hold_pc_nxt    = r_hold_pc;
    w_hold_instr_nxt = r_hold_instr;
    w_valid_nxt      = r_valid;
    w_pc_nxt         = r_pc;
    w_instr_nxt      = r_instr;

    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
      end

      S_FETCH: begin
        if (flush_in) begin
          // Squash: bubble into decode, drop the buffered word and any word arriving now.
          w_valid_nxt      = 1'b0;
          w_instr_nxt      = NOP_INSTR;
          w_hold_valid_nxt = 1'b0;
          if (w_req && !imem_ready) begin
            // The bus request must run to completion at its old address first.
            w_redir_pc_nxt = w_target;
            w_state_nxt    = S_DROP;
          end else begin
            w_fetch_pc_nxt = w_target;
          end
        end else if (!stall_in) begin
          if (r_hold_valid) begin
            w_valid_nxt      = 1'b1;
            w_pc_nxt         = r_hold_pc;
            w_instr_nxt      = r_hold_instr;
            w_hold_valid_nxt = 1'b0;
          end else if (w_complete) begin
            w_valid_nxt    = 1'b1;
            w_pc_nxt       = r_fetch_pc;
            w_instr_nxt    = imem_rdata;
            w_fetch_pc_nxt = w_pc_plus4;
          end else begin
            w_valid_nxt = 1'b0;
          end
        end else if (w_complete) begin
          // Decode is stalled: park the returning word so it is not lost.
          w_hold_valid_nxt = 1'b1;
          w_hold_pc_nxt    = r_fetch_pc;
          w_hold_instr_nxt = imem_rdata;
          w_fetch_pc_nxt   = w_pc_plus4;
        end
      end

      S_DROP: begin
        // Bubble persists while the squashed request drains; stall has no effect here.
        w_valid_nxt = 1'b0;
        if (flush_in) begin
          w_instr_nxt    = NOP_INSTR;
          w_redir_pc_nxt = w_target;
        end
        if (imem_ready) begin
          w_fetch_pc_nxt = flush_in ? w_target : r_redir_pc;
          w_state_nxt    = S_FETCH;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and pipeline registers, cleared asynchronously so a mid-request reset aborts at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_fetch_pc   <= RESET_PC;
      r_redir_pc   <= RESET_PC;
      r_hold_valid <= 1'b0;
      r_hold_pc    <= 32'd0;
      r_hold_instr <= NOP_INSTR;
      r_valid      <= 1'b0;
      r_pc         <= 32'd0;
      r_instr      <= NOP_INSTR;
    end else begin
      r_state      <= w_state_nxt;
      r_fetch_pc   <= w_fetch_pc_nxt;
      r_redir_pc   <= w_redir_pc_nxt;
      r_hold_valid <= w_hold_valid_nxt;
      r_hold_pc    <= w_hold_pc_nxt;
      r_hold_instr <= w_hold_instr_nxt;
      r_valid      <= w_valid_nxt;
      r_pc         <= w_pc_nxt;
      r_instr      <= w_instr_nxt;
    end
  end

  assign valid_out  = r_valid;
  assign pc_out     = r_pc;
  assign instr_out  = r_instr;
  assign rs1_out    = r_instr[19:15];
  assign rs2_out    = r_instr[24:20];
  assign rd_out     = r_instr[11:7];
  assign funct3_out = r_instr[14:12];
  assign funct7_out = r_instr[31:25];

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// tb/tb_if_id_fetch_stage.sv - scoreboard bench for if_id_fetch_stage
module tb_if_id_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall_in;
  logic        flush_in;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        valid_out;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic [4:0]  rs1_out;
  logic [4:0]  rs2_out;
  logic [4:0]  rd_out;
  logic [2:0]  funct3_out;
  logic [6:0]  funct7_out;

  int tests_run;
  int tests_failed;

  // Expected IF/ID contents {pc, instr}, pushed when the completing request is driven.
  logic [63:0] sb_q[$];
  logic [63:0] e;
  logic [31:0] exp_pc;
  logic [31:0] exp_w;

  if_id_fetch_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall_in   (stall_in),
    .flush_in   (flush_in),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .valid_out  (valid_out),
    .pc_out     (pc_out),
    .instr_out  (instr_out),
    .rs1_out    (rs1_out),
    .rs2_out    (rs2_out),
    .rd_out     (rd_out),
    .funct3_out (funct3_out),
    .funct7_out (funct7_out)
  );

  // Memory model: each word's content is its address plus 0x1000.
  assign imem_rdata = imem_addr + 32'h0000_1000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    rst_n = 1'b0; stall_in = 1'b0; flush_in = 1'b0; redirect_pc = 32'd0; imem_ready = 1'b0;
    sb_q.delete();
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall_in = 1'b0; flush_in = 1'b0; redirect_pc = 32'd0; imem_ready = 1'b0;
    tick(); tick();
    tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL rst_req got %0h want 0", imem_req); end
    tests_run++; if (valid_out !== 1'b0) begin tests_failed++; $display("FAIL rst_valid got %0h want 0", valid_out); end
    tests_run++; if (pc_out !== 32'd0) begin tests_failed++; $display("FAIL rst_pc got %08h want 0", pc_out); end
    tests_run++; if (instr_out !== 32'h13) begin tests_failed++; $display("FAIL rst_instr got %08h want 00000013", instr_out); end
    tests_run++; if ({funct7_out, rs2_out, rs1_out, funct3_out, rd_out} !== 25'd0) begin
      tests_failed++; $display("FAIL rst_fields got %0h want 0", {funct7_out, rs2_out, rs1_out, funct3_out, rd_out}); end
    rst_n = 1'b1;
    #1;
    tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL idle_req got %0h want 0", imem_req); end
    tick();
    tests_run++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      tests_failed++; $display("FAIL first_req got %0h/%08h want 1/00000000", imem_req, imem_addr); end
  endtask

  task automatic test_reset_mid();
    start();
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    tests_run++; if ({imem_req, valid_out, instr_out} !== {1'b0, 1'b0, 32'h13}) begin
      tests_failed++; $display("FAIL mid_rst got req %0h valid %0h instr %08h want 0 0 00000013", imem_req, valid_out, instr_out); end
    tick();
    rst_n = 1'b1;
    #1;
    tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_idle got %0h want 0", imem_req); end
    tick();
    tests_run++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      tests_failed++; $display("FAIL mid_rst_refetch got %0h/%08h want 1/00000000", imem_req, imem_addr); end
  endtask

  task automatic test_stream();
    start();
    imem_ready = 1'b1;
    exp_pc = 32'd0;
    for (int i = 0; i < 6; i++) begin
      tests_run++; if ({imem_req, imem_addr} !== {1'b1, exp_pc}) begin
        tests_failed++; $display("FAIL stream_addr%0d got %0h/%08h want 1/%08h", i, imem_req, imem_addr, exp_pc); end
      sb_q.push_back({exp_pc, exp_pc + 32'h1000});
      exp_pc = exp_pc + 32'd4;
      tick();
      e = sb_q.pop_front();
      tests_run++; if ({valid_out, pc_out, instr_out} !== {1'b1, e}) begin
        tests_failed++; $display("FAIL stream_out%0d got %0h %08h %08h want 1 %08h %08h", i, valid_out, pc_out, instr_out, e[63:32], e[31:0]); end
    end
  endtask

  task automatic test_stall();
    start();
    imem_ready = 1'b1;
    sb_q.push_back({32'h0, 32'h1000}); tick();
    sb_q.push_back({32'h4, 32'h1004}); tick();
    e = sb_q.pop_front();
    e = sb_q.pop_front();
    tests_run++; if ({valid_out, pc_out} !== {1'b1, 32'h4}) begin
      tests_failed++; $display("FAIL stall_pre got %0h %08h want 1 00000004", valid_out, pc_out); end
    stall_in = 1'b1;
    sb_q.push_back({32'h8, 32'h1008});
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++; if ({valid_out, pc_out, instr_out, imem_req} !== {1'b1, 32'h4, 32'h1004, 1'b0}) begin
        tests_failed++; $display("FAIL stall_hold%0d got %0h %08h %08h req %0h want 1 00000004 00001004 req 0", i, valid_out, pc_out, instr_out, imem_req); end
    end
    stall_in = 1'b0;
    tick();
    e = sb_q.pop_front();
    tests_run++; if ({valid_out, pc_out, instr_out} !== {1'b1, e}) begin
      tests_failed++; $display("FAIL stall_rel got %0h %08h %08h want 1 %08h %08h", valid_out, pc_out, instr_out, e[63:32], e[31:0]); end
    tests_run++; if ({imem_req, imem_addr} !== {1'b1, 32'hC}) begin
      tests_failed++; $display("FAIL stall_next got %0h/%08h want 1/0000000c", imem_req, imem_addr); end
    sb_q.push_back({32'hC, 32'h100C});
    tick();
    e = sb_q.pop_front();
    tests_run++; if ({valid_out, pc_out, instr_out} !== {1'b1, e}) begin
      tests_failed++; $display("FAIL stall_after got %0h %08h %08h want 1 %08h %08h", valid_out, pc_out, instr_out, e[63:32], e[31:0]); end
  endtask

  task automatic test_flush();
    start();
    imem_ready = 1'b1;
    tick(); tick();
    flush_in = 1'b1; redirect_pc = 32'h100;
    tick();
    flush_in = 1'b0;
    tests_run++; if ({valid_out, instr_out, imem_req, imem_addr} !== {1'b0, 32'h13, 1'b1, 32'h100}) begin
      tests_failed++; $display("FAIL flush_bubble got %0h %08h req %0h %08h want 0 00000013 req 1 00000100", valid_out, instr_out, imem_req, imem_addr); end
    sb_q.push_back({32'h100, 32'h1100});
    tick();
    e = sb_q.pop_front();
    tests_run++; if ({valid_out, pc_out, instr_out} !== {1'b1, e}) begin
      tests_failed++; $display("FAIL flush_target got %0h %08h %08h want 1 %08h %08h", valid_out, pc_out, instr_out, e[63:32], e[31:0]); end
    flush_in = 1'b1; redirect_pc = 32'h5AB3_C784;
    tick();
    flush_in = 1'b0;
    sb_q.push_back({32'h5AB3_C784, 32'h5AB3_D784});
    tick();
    e = sb_q.pop_front();
    exp_w = e[31:0];
    tests_run++; if ({valid_out, pc_out, instr_out} !== {1'b1, e}) begin
      tests_failed++; $display("FAIL fields_word got %0h %08h %08h want 1 %08h %08h", valid_out, pc_out, instr_out, e[63:32], e[31:0]); end
    tests_run++; if ({funct7_out, rs2_out, rs1_out, funct3_out, rd_out} !== {exp_w[31:25], exp_w[24:20], exp_w[19:15], exp_w[14:12], exp_w[11:7]}) begin
      tests_failed++; $display("FAIL fields got %0h %0h %0h %0h %0h want %0h %0h %0h %0h %0h", funct7_out, rs2_out, rs1_out, funct3_out, rd_out,
                               exp_w[31:25], exp_w[24:20], exp_w[19:15], exp_w[14:12], exp_w[11:7]); end
  endtask

  task automatic test_drop();
    start();
    imem_ready = 1'b1;
    tick(); tick();
    imem_ready = 1'b0;
    tick();
    tests_run++; if ({valid_out, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h8}) begin
      tests_failed++; $display("FAIL drop_wait got %0h req %0h %08h want 0 req 1 00000008", valid_out, imem_req, imem_addr); end
    flush_in = 1'b1; redirect_pc = 32'h200;
    tick();
    flush_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tests_run++; if ({valid_out, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h8}) begin
        tests_failed++; $display("FAIL drop_hold%0d got %0h req %0h %08h want 0 req 1 00000008", i, valid_out, imem_req, imem_addr); end
      tick();
    end
    imem_ready = 1'b1;
    tick();
    tests_run++; if ({valid_out, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h200}) begin
      tests_failed++; $display("FAIL drop_done got %0h req %0h %08h want 0 req 1 00000200", valid_out, imem_req, imem_addr); end
    sb_q.push_back({32'h200, 32'h1200});
    tick();
    e = sb_q.pop_front();
    tests_run++; if ({valid_out, pc_out, instr_out} !== {1'b1, e}) begin
      tests_failed++; $display("FAIL drop_target got %0h %08h %08h want 1 %08h %08h", valid_out, pc_out, instr_out, e[63:32], e[31:0]); end
  endtask

  task automatic test_flush_stall_drop();
    start();
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0; stall_in = 1'b1; flush_in = 1'b1; redirect_pc = 32'h200;
    tick();
    tests_run++; if ({valid_out, instr_out, imem_req, imem_addr} !== {1'b0, 32'h13, 1'b1, 32'h4}) begin
      tests_failed++; $display("FAIL fs_bubble got %0h %08h req %0h %08h want 0 00000013 req 1 00000004", valid_out, instr_out, imem_req, imem_addr); end
    stall_in = 1'b0; redirect_pc = 32'h300;
    tick();
    flush_in = 1'b0;
    tests_run++; if ({valid_out, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h4}) begin
      tests_failed++; $display("FAIL fs_drop got %0h req %0h %08h want 0 req 1 00000004", valid_out, imem_req, imem_addr); end
    imem_ready = 1'b1;
    tick();
    tests_run++; if ({valid_out, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h300}) begin
      tests_failed++; $display("FAIL fs_latest got %0h req %0h %08h want 0 req 1 00000300", valid_out, imem_req, imem_addr); end
    sb_q.push_back({32'h300, 32'h1300});
    tick();
    e = sb_q.pop_front();
    tests_run++; if ({valid_out, pc_out, instr_out} !== {1'b1, e}) begin
      tests_failed++; $display("FAIL fs_target got %0h %08h %08h want 1 %08h %08h", valid_out, pc_out, instr_out, e[63:32], e[31:0]); end
    stall_in = 1'b1; flush_in = 1'b1; redirect_pc = 32'h400;
    tick();
    stall_in = 1'b0; flush_in = 1'b0;
    tests_run++; if ({valid_out, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h400}) begin
      tests_failed++; $display("FAIL fs_complete got %0h req %0h %08h want 0 req 1 00000400", valid_out, imem_req, imem_addr); end
  endtask

  task automatic test_wrap();
    start();
    imem_ready = 1'b1;
    flush_in = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    flush_in = 1'b0;
    tests_run++; if ({valid_out, imem_addr} !== {1'b0, 32'hFFFF_FFFC}) begin
      tests_failed++; $display("FAIL wrap_align got %0h %08h want 0 fffffffc", valid_out, imem_addr); end
    sb_q.push_back({32'hFFFF_FFFC, 32'h0000_0FFC});
    tick();
    e = sb_q.pop_front();
    tests_run++; if ({valid_out, pc_out, instr_out, imem_addr} !== {1'b1, e, 32'h0}) begin
      tests_failed++; $display("FAIL wrap_top got %0h %08h %08h addr %08h want 1 %08h %08h addr 00000000", valid_out, pc_out, instr_out, imem_addr, e[63:32], e[31:0]); end
    sb_q.push_back({32'h0, 32'h1000});
    tick();
    e = sb_q.pop_front();
    tests_run++; if ({valid_out, pc_out, instr_out} !== {1'b1, e}) begin
      tests_failed++; $display("FAIL wrap_zero got %0h %08h %08h want 1 %08h %08h", valid_out, pc_out, instr_out, e[63:32], e[31:0]); end
  endtask

  // Scenario sequence.
  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_reset_mid();
    test_stream();
    test_stall();
    test_flush();
    test_drop();
    test_flush_stall_drop();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
